// File: rtl/etch_pkg.sv
// etch_pkg: constants and helpers shared by the trace tile-RAM writer, the
// display read path and the UART map dump.
//   MAX_X / MAX_Y        last tile column / row index of the 80x30 map
//   SET_CHAR / CLR_CHAR  ASCII art bytes for a traced / blank tile
//   ASCII_CR / ASCII_LF  row terminator bytes
//   tile_addr(y, x)      packs a tile coordinate into the 12-bit RAM address
package etch_pkg;

   localparam int         MAX_X    = 79;
   localparam int         MAX_Y    = 29;
   localparam logic [7:0] SET_CHAR = 8'h23;
   localparam logic [7:0] CLR_CHAR = 8'h2E;
   localparam logic [7:0] ASCII_CR = 8'h0D;
   localparam logic [7:0] ASCII_LF = 8'h0A;

   // Scan FSM states of the dump engine
   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_ADDR = 3'd1,
      S_WAIT = 3'd2,
      S_LOAD = 3'd3,
      S_SEND = 3'd4,
      S_CR   = 3'd5,
      S_LF   = 3'd6,
      S_FIN  = 3'd7
   } dump_state_t;

   // Which kind of byte is currently on the wire; decides where SEND goes next
   typedef enum logic [1:0] {
      PH_CHAR = 2'd0,
      PH_CR   = 2'd1,
      PH_LF   = 2'd2
   } tx_phase_t;

   // Tile RAM address layout: row in the upper bits, column in the lower 7
   function automatic logic [11:0] tile_addr(input logic [4:0] y, input logic [6:0] x);
      return {y, x};
   endfunction

endpackage

// File: rtl/trace_map_uart_dump_uart_tx_byte.sv
// uart_tx_byte: 8N1 serial transmitter for a single byte.
//   clk_100MHz  in   system clock
//   reset       in   asynchronous, active-high
//   tx_start    in   load tx_data and begin a frame (accepted only when idle)
//   tx_data     in   byte to send, LSB first
//   tx          out  serial line, idle high
//   tx_ready    out  high when idle, i.e. once the stop bit has fully elapsed
// Every bit lasts exactly CLK_HZ/BAUD (truncated) clock cycles; the start bit
// begins in the cycle after tx_start.
module uart_tx_byte #(
   parameter int CLK_HZ = 100_000_000,
   parameter int BAUD   = 115200
) (
   input  logic       clk_100MHz,
   input  logic       reset,
   input  logic       tx_start,
   input  logic [7:0] tx_data,
   output logic       tx,
   output logic       tx_ready
);

   localparam int BIT_CYC = CLK_HZ / BAUD;
   localparam int CNT_W   = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYC - 1);

   // frame_q holds {stop, data[7:0], start}; bit 0 is always the line level,
   // and shifting in ones leaves the line idle high after the stop bit.
   logic [9:0]       frame_q, frame_d;
   logic [3:0]       bit_q, bit_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             active_q, active_d;

   // Next-state logic for the bit timer and frame shifter
   always_comb begin
      frame_d  = frame_q;
      bit_d    = bit_q;
      cnt_d    = cnt_q;
      active_d = active_q;
      if (!active_q) begin
         if (tx_start) begin
            frame_d  = {1'b1, tx_data, 1'b0};
            bit_d    = 4'd0;
            cnt_d    = '0;
            active_d = 1'b1;
         end else begin
            frame_d = 10'h3FF;
         end
      end else if (cnt_q == CNT_LAST) begin
         cnt_d   = '0;
         frame_d = {1'b1, frame_q[9:1]};
         if (bit_q == 4'd9) begin
            active_d = 1'b0;
         end else begin
            bit_d = bit_q + 4'd1;
         end
      end else begin
         cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   // Transmitter state registers
   always_ff @(posedge clk_100MHz or posedge reset) begin
      if (reset) begin
         frame_q  <= 10'h3FF;
         bit_q    <= 4'd0;
         cnt_q    <= '0;
         active_q <= 1'b0;
      end else begin
         frame_q  <= frame_d;
         bit_q    <= bit_d;
         cnt_q    <= cnt_d;
         active_q <= active_d;
      end
   end

   assign tx       = frame_q[0];
   assign tx_ready = ~active_q;

endmodule

// File: rtl/trace_map_uart_dump.sv
// trace_map_uart_dump: on a start pulse, scans the trace tile map row by row
// and sends it over UART as ASCII art ('#' traced, '.' blank, CR LF per row).
//   clk_100MHz  in   system clock
//   reset       in   asynchronous, active-high
//   start       in   1-cycle request pulse, ignored while busy
//   ram_addr    out  tile RAM read address {y, x}
//   ram_dout    in   tile RAM read data, valid one cycle after ram_addr
//   busy        out  dump in progress (top level freezes drawing meanwhile)
//   done        out  1-cycle pulse in the cycle busy falls
//   row         out  row currently being sent
//   tx          out  UART serial out, idle high
module trace_map_uart_dump #(
   parameter int         CLK_HZ   = 100_000_000,
   parameter int         BAUD     = 115200,
   parameter int         MAX_X    = etch_pkg::MAX_X,
   parameter int         MAX_Y    = etch_pkg::MAX_Y,
   parameter logic [7:0] SET_CHAR = etch_pkg::SET_CHAR,
   parameter logic [7:0] CLR_CHAR = etch_pkg::CLR_CHAR
) (
   input  logic        clk_100MHz,
   input  logic        reset,
   input  logic        start,
   output logic [11:0] ram_addr,
   input  logic [6:0]  ram_dout,
   output logic        busy,
   output logic        done,
   output logic [4:0]  row,
   output logic        tx
);

   import etch_pkg::*;

   localparam logic [6:0] X_LAST = 7'(MAX_X);
   localparam logic [4:0] Y_LAST = 5'(MAX_Y);

   dump_state_t state_q, state_d;
   tx_phase_t   phase_q, phase_d;
   logic [6:0]  x_q, x_d;
   logic [4:0]  y_q, y_d;
   logic [4:0]  row_q, row_d;
   logic [11:0] ram_addr_q, ram_addr_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;

   logic        tx_start_s;
   logic [7:0]  tx_data_s;
   logic        tx_ready_s;

   // Scan sequencing: address, RAM latency, byte load, then wait for the UART
   always_comb begin
      state_d    = state_q;
      phase_d    = phase_q;
      x_d        = x_q;
      y_d        = y_q;
      row_d      = row_q;
      ram_addr_d = ram_addr_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      tx_start_s = 1'b0;
      tx_data_s  = CLR_CHAR;
      case (state_q)
         // FIN behaves like IDLE so a start in the done cycle is taken
         S_IDLE, S_FIN: begin
            if (start) begin
               x_d     = 7'd0;
               y_d     = 5'd0;
               row_d   = 5'd0;
               busy_d  = 1'b1;
               state_d = S_ADDR;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_ADDR: begin
            ram_addr_d = tile_addr(y_q, x_q);
            state_d    = S_WAIT;
         end
         S_WAIT: begin
            state_d = S_LOAD;
         end
         S_LOAD: begin
            tx_start_s = 1'b1;
            tx_data_s  = (ram_dout != 7'd0) ? SET_CHAR : CLR_CHAR;
            phase_d    = PH_CHAR;
            state_d    = S_SEND;
         end
         S_CR: begin
            tx_start_s = 1'b1;
            tx_data_s  = ASCII_CR;
            phase_d    = PH_CR;
            state_d    = S_SEND;
         end
         S_LF: begin
            tx_start_s = 1'b1;
            tx_data_s  = ASCII_LF;
            phase_d    = PH_LF;
            state_d    = S_SEND;
         end
         // Column/row stepping is decided here so the next start bit
         // follows the stop bit within the ADDR/WAIT/LOAD overhead.
         S_SEND: begin
            if (tx_ready_s) begin
               case (phase_q)
                  PH_CHAR: begin
                     if (x_q < X_LAST) begin
                        x_d     = x_q + 7'd1;
                        state_d = S_ADDR;
                     end else begin
                        state_d = S_CR;
                     end
                  end
                  PH_CR: begin
                     state_d = S_LF;
                  end
                  PH_LF: begin
                     if (y_q < Y_LAST) begin
                        y_d     = y_q + 5'd1;
                        x_d     = 7'd0;
                        row_d   = y_q + 5'd1;
                        state_d = S_ADDR;
                     end else begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_FIN;
                     end
                  end
                  default: begin
                     busy_d  = 1'b0;
                     state_d = S_IDLE;
                  end
               endcase
            end else begin
               state_d = S_SEND;
            end
         end
         default: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   // Scan FSM, counters and registered outputs
   always_ff @(posedge clk_100MHz or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         phase_q    <= PH_CHAR;
         x_q        <= 7'd0;
         y_q        <= 5'd0;
         row_q      <= 5'd0;
         ram_addr_q <= 12'd0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         phase_q    <= phase_d;
         x_q        <= x_d;
         y_q        <= y_d;
         row_q      <= row_d;
         ram_addr_q <= ram_addr_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign ram_addr = ram_addr_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign row      = row_q;

   uart_tx_byte #(
      .CLK_HZ (CLK_HZ),
      .BAUD   (BAUD)
   ) u_uart_tx (
      .clk_100MHz (clk_100MHz),
      .reset      (reset),
      .tx_start   (tx_start_s),
      .tx_data    (tx_data_s),
      .tx         (tx),
      .tx_ready   (tx_ready_s)
   );

endmodule

// File: tb/tb_trace_map_uart_dump.sv
// Testbench for trace_map_uart_dump on a reduced 8x4 map with a 3-cycle bit
// time (1000 Hz / 280 baud, truncated), so whole dumps stay short.
module tb_trace_map_uart_dump;

   localparam int MX = 7;
   localparam int MY = 3;
   localparam int BC = 3;                       // 1000 / 280 truncated
   localparam int DUMP_BYTES = (MY + 1) * (MX + 3);

   logic        clk_100MHz;
   logic        reset;
   logic        start;
   logic [11:0] ram_addr;
   logic [6:0]  ram_dout;
   logic        busy;
   logic        done;
   logic [4:0]  row;
   logic        tx;

   logic [6:0]  mem [0:4095];
   logic [7:0]  exp_q [$];

   int n_tests  = 0;
   int n_fail   = 0;
   int rx_count = 0;
   int done_cnt = 0;

   trace_map_uart_dump #(
      .CLK_HZ   (1000),
      .BAUD     (280),
      .MAX_X    (MX),
      .MAX_Y    (MY),
      .SET_CHAR (8'h23),
      .CLR_CHAR (8'h2E)
   ) dut (
      .clk_100MHz (clk_100MHz),
      .reset      (reset),
      .start      (start),
      .ram_addr   (ram_addr),
      .ram_dout   (ram_dout),
      .busy       (busy),
      .done       (done),
      .row        (row),
      .tx         (tx)
   );

   initial clk_100MHz = 1'b0;
   always #5 clk_100MHz = ~clk_100MHz;

   // Synchronous tile RAM model
   always_ff @(posedge clk_100MHz) begin
      ram_dout <= mem[ram_addr];
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Expected byte stream for the current RAM contents
   task automatic push_dump();
      for (int y = 0; y <= MY; y++) begin
         for (int x = 0; x <= MX; x++) begin
            exp_q.push_back((mem[y * 128 + x] != 7'd0) ? 8'h23 : 8'h2E);
         end
         exp_q.push_back(8'h0D);
         exp_q.push_back(8'h0A);
      end
   endtask

   task automatic pulse_start();
      @(posedge clk_100MHz);
      #1 start = 1'b1;
      @(posedge clk_100MHz);
      #1 start = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      int n;
      n = 0;
      while (done !== 1'b1 && n < budget) begin
         @(negedge clk_100MHz);
         n++;
      end
      check_val(tag, (n < budget), 1'b1);
   endtask

   // Count done pulses
   initial begin
      forever begin
         @(negedge clk_100MHz);
         if (done === 1'b1) done_cnt++;
      end
   end

   // UART receiver: every bit must hold for exactly BC samples; received
   // bytes are compared against the scoreboard queue.
   initial begin
      int         ph;
      int         smp;
      int         gap;
      bit         gap_ok;
      bit         steady;
      logic [9:0] bits;
      logic [7:0] want;
      ph = -1; smp = 0; gap = 0; gap_ok = 1'b0; steady = 1'b1; bits = '1;
      forever begin
         @(negedge clk_100MHz);
         if (reset) begin
            ph = -1;
            gap_ok = 1'b0;
         end else if (ph < 0) begin
            if (tx === 1'b0) begin
               if (gap_ok) check_val("idle_gap_le4", (gap <= 4), 1'b1);
               ph = 0; smp = 1; steady = 1'b1; bits[0] = tx;
            end else begin
               gap++;
               if (busy !== 1'b1) gap_ok = 1'b0;
            end
         end else begin
            if (smp == 0) bits[ph] = tx;
            else if (tx !== bits[ph]) steady = 1'b0;
            smp++;
            if (smp == BC) begin
               smp = 0;
               ph++;
               if (ph == 10) begin
                  rx_count++;
                  check_val($sformatf("frame_shape_%0d", rx_count),
                            {29'd0, steady, bits[0], bits[9]}, 32'd5);
                  if (exp_q.size() == 0) begin
                     check_val("unexpected_byte", bits[8:1], 32'hFFFF);
                  end else begin
                     want = exp_q.pop_front();
                     check_val($sformatf("byte_%0d", rx_count), bits[8:1], want);
                  end
                  ph = -1; gap = 0; gap_ok = busy;
               end
            end
         end
      end
   end

   initial begin
      int base_rx;
      int base_done;
      int n;
      int edges;
      logic prev;

      reset = 1'b1;
      start = 1'b0;
      for (int i = 0; i < 4096; i++) mem[i] = 7'd0;

      // Reset values
      repeat (3) @(posedge clk_100MHz);
      #1;
      check_val("rst_tx", tx, 1'b1);
      check_val("rst_busy", busy, 1'b0);
      check_val("rst_done", done, 1'b0);
      check_val("rst_row", row, 5'd0);
      check_val("rst_ram_addr", ram_addr, 12'd0);
      reset = 1'b0;
      repeat (2) @(posedge clk_100MHz);

      // All-zero map: full dump of dots with CR LF per row
      base_rx = rx_count; base_done = done_cnt;
      push_dump();
      pulse_start();
      check_val("busy_after_start", busy, 1'b1);
      wait_done("dump0_done_seen", 6000);
      check_val("busy_in_done_cycle", busy, 1'b0);
      repeat (3) @(negedge clk_100MHz);
      check_val("dump0_bytes", rx_count - base_rx, DUMP_BYTES);
      check_val("dump0_done_pulses", done_cnt - base_done, 1);
      check_val("dump0_queue_empty", exp_q.size(), 0);
      check_val("dump0_row_last", row, MY);
      check_val("dump0_idle", busy, 1'b0);

      // Reset in the middle of a frame, after three data bits
      pulse_start();
      n = 0;
      while (tx !== 1'b0 && n < 50) begin
         @(negedge clk_100MHz);
         n++;
      end
      check_val("midrst_frame_seen", (n < 50), 1'b1);
      repeat (4 * BC + 1) @(negedge clk_100MHz);
      #2 reset = 1'b1;
      #1;
      check_val("midrst_tx", tx, 1'b1);
      check_val("midrst_busy", busy, 1'b0);
      check_val("midrst_done", done, 1'b0);
      repeat (2) @(posedge clk_100MHz);
      #1 reset = 1'b0;
      prev = tx;
      edges = 0;
      repeat (40) begin
         @(negedge clk_100MHz);
         if (tx !== prev) edges++;
         prev = tx;
      end
      check_val("midrst_no_tx_edges", edges, 0);
      check_val("midrst_busy_after", busy, 1'b0);

      // Two set cells: first row column 5, and the very last tile
      mem[5] = 7'h01;
      mem[MY * 128 + MX] = 7'h41;
      base_rx = rx_count; base_done = done_cnt;
      push_dump();
      pulse_start();
      check_val("busy_after_start2", busy, 1'b1);
      wait_done("dump1_done_seen", 6000);
      repeat (3) @(negedge clk_100MHz);
      check_val("dump1_bytes", rx_count - base_rx, DUMP_BYTES);
      check_val("dump1_done_pulses", done_cnt - base_done, 1);
      check_val("dump1_queue_empty", exp_q.size(), 0);

      // Random map; extra start mid-dump, then start again in the done cycle
      for (int y = 0; y <= MY; y++) begin
         for (int x = 0; x <= MX; x++) begin
            mem[y * 128 + x] = ($urandom_range(0, 2) == 0) ? 7'($urandom_range(1, 127)) : 7'd0;
         end
      end
      base_rx = rx_count; base_done = done_cnt;
      push_dump();
      pulse_start();
      n = 0;
      while (rx_count - base_rx < 10 && n < 2000) begin
         @(negedge clk_100MHz);
         n++;
      end
      check_val("dump2_reach_byte10", (n < 2000), 1'b1);
      pulse_start();
      check_val("busy_ignored_start", busy, 1'b1);
      wait_done("dump2_done_seen", 6000);
      push_dump();
      start = 1'b1;
      @(posedge clk_100MHz);
      #1 start = 1'b0;
      check_val("busy_after_done_start", busy, 1'b1);
      wait_done("dump3_done_seen", 6000);
      repeat (3) @(negedge clk_100MHz);
      check_val("dump23_bytes", rx_count - base_rx, 2 * DUMP_BYTES);
      check_val("dump23_done_pulses", done_cnt - base_done, 2);
      check_val("dump23_queue_empty", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
